cpu_step_ctrl: RTL and testbench

//  Clock-enable sequencer for the pipeline CPU: replaces the free-running button pulse with a

---
 rtl/cpu_step_ctrl_pkg.sv | 21 ++
 rtl/cpu_step_ctrl_btn_debounce.sv | 66 ++++++
 rtl/cpu_step_ctrl.sv | 124 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_ctrl_pkg
//  Description : Shared state encodings for the CPU step/run sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_step_ctrl_pkg;

    localparam int c_STATE_W = 3;

    // Encodings are visible on the debug 'state' port, so they are fixed.
    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_step_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer plus stable-level debounce counter for
//                the raw step button; emits a one-cycle press pulse on the
//                debounced rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam int              c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1_q;
    logic               r_sync2_q;
    logic               r_db_q;
    logic               r_db_prev_q;
    logic [c_CNT_W-1:0] r_cnt_q;

    logic               w_db_d;
    logic [c_CNT_W-1:0] w_cnt_d;

    // Accept a new level only after enough consecutive disagreeing samples.
    always_comb begin
        w_db_d  = r_db_q;
        w_cnt_d = '0;
        if (r_sync2_q != r_db_q) begin
            if (r_cnt_q == c_CNT_LAST) begin
                w_db_d  = r_sync2_q;
                w_cnt_d = '0;
            end else begin
                w_cnt_d = r_cnt_q + c_CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounced level and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q   <= 1'b0;
            r_sync2_q   <= 1'b0;
            r_db_q      <= 1'b0;
            r_db_prev_q <= 1'b0;
            r_cnt_q     <= '0;
        end else begin
            r_sync1_q   <= btn_raw;
            r_sync2_q   <= r_sync1_q;
            r_db_q      <= w_db_d;
            r_db_prev_q <= r_db_q;
            r_cnt_q     <= w_cnt_d;
        end
    end

    assign btn_db = r_db_q;
    assign press  = r_db_q & ~r_db_prev_q;

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_ctrl
//  Description : CPU clock-enable sequencer: single-step on debounced button,
//                free-run on run_mode, halt on halt_req or breakpoint match.
//                Counts issued cpu_ce cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int ADDR_W          = 8,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic              run_mode,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              halt_req,
    output logic              cpu_ce,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  step_count,
    output logic              at_break
);

    logic             w_btn_db;
    logic             w_press;
    logic             w_stop;
    logic             w_cpu_ce;
    logic             w_at_break;

    state_e           r_state_q;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_step_count_q;
    logic [CNT_W-1:0] w_step_count_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (button),
        .btn_db  (w_btn_db),
        .press   (w_press)
    );

    // The breakpoint is checked against the address about to be fetched, so
    // stopping here keeps the breakpoint instruction out of the pipeline.
    assign w_stop = halt_req | (bp_en & (i_addr == bp_addr));

    // Next-state and clock-enable decode.
    always_comb begin
        w_state_d  = r_state_q;
        w_cpu_ce   = 1'b0;
        w_at_break = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (run_mode & ~halt_req) begin
                    w_state_d = ST_RUN;
                end else if (w_press) begin
                    w_state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                w_cpu_ce  = 1'b1;
                w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Hold here until release so a held button gives one step.
                if (~w_btn_db) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_d = ST_BREAK;
                end else if (~run_mode) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_cpu_ce = 1'b1;
                end
            end
            ST_BREAK: begin
                w_at_break = 1'b1;
                // STEP does not check the breakpoint, so a press steps past it.
                if (w_press) begin
                    w_state_d = ST_STEP;
                end else if (~run_mode) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Issued-cycle counter, wraps silently.
    always_comb begin
        w_step_count_d = r_step_count_q + CNT_W'(w_cpu_ce);
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_step_count_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_step_count_q <= w_step_count_d;
        end
    end

    assign cpu_ce     = w_cpu_ce;
    assign state      = r_state_q;
    assign step_count = r_step_count_q;
    assign at_break   = w_at_break;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_step_ctrl
//  Description : Self-checking bench for cpu_step_ctrl with a cycle-level
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

    localparam int N = 4;

    localparam int S_IDLE  = 0;
    localparam int S_STEP  = 1;
    localparam int S_WAIT  = 2;
    localparam int S_RUN   = 3;
    localparam int S_BREAK = 4;

    logic        clk;
    logic        reset;
    logic        button;
    logic        run_mode;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  i_addr;
    logic        halt_req;
    logic        cpu_ce;
    logic [2:0]  state;
    logic [15:0] step_count;
    logic        at_break;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_state;
    logic [15:0] m_count;
    logic [7:0]  m_pc;
    bit          m_raw1, m_raw2, m_db, m_db_prev;
    bit          m_hist[$];

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES (N),
        .ADDR_W          (8),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .run_mode   (run_mode),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .i_addr     (i_addr),
        .halt_req   (halt_req),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .step_count (step_count),
        .at_break   (at_break)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance
    // the model over the rising edge.
    task automatic cycle();
        bit press, stop, ce, all_differ;
        int nxt;
        press = m_db && !m_db_prev;
        stop  = halt_req || (bp_en && (i_addr == bp_addr));
        ce    = (m_state == S_STEP) || (m_state == S_RUN && run_mode && !stop);
        @(negedge clk);
        chk("state",      32'(state),      32'(m_state));
        chk("cpu_ce",     32'(cpu_ce),     32'(ce));
        chk("step_count", 32'(step_count), 32'(m_count));
        chk("at_break",   32'(at_break),   32'(m_state == S_BREAK));
        @(posedge clk);
        if (reset) begin
            m_state = S_IDLE; m_count = '0;
            m_raw1 = 0; m_raw2 = 0; m_db = 0; m_db_prev = 0;
            m_hist.delete();
        end else begin
            nxt = m_state;
            case (m_state)
                S_IDLE:  if (run_mode && !halt_req) nxt = S_RUN; else if (press) nxt = S_STEP;
                S_STEP:  nxt = S_WAIT;
                S_WAIT:  if (!m_db) nxt = S_IDLE;
                S_RUN:   if (stop) nxt = S_BREAK; else if (!run_mode) nxt = S_IDLE;
                S_BREAK: if (press) nxt = S_STEP; else if (!run_mode) nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
            m_state = nxt;
            if (ce) begin
                m_count = m_count + 16'd1;
                m_pc    = m_pc + 8'd1;
            end
            // Debounced level flips once the last N synchronized samples all disagree.
            m_hist.push_back(m_raw2);
            if (m_hist.size() > N) void'(m_hist.pop_front());
            all_differ = (m_hist.size() == N);
            foreach (m_hist[k]) if (m_hist[k] == m_db) all_differ = 0;
            m_db_prev = m_db;
            if (all_differ) m_db = !m_db;
            m_raw2 = m_raw1;
            m_raw1 = button;
        end
        #1;
    endtask

    task automatic cycles(input int n, input bit track_pc);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (track_pc) i_addr = m_pc;
        end
    endtask

    initial begin
        reset = 1; button = 0; run_mode = 0; bp_en = 0; bp_addr = 0;
        i_addr = 0; halt_req = 0; m_pc = 0;
        m_state = S_IDLE; m_count = 0; m_raw1 = 0; m_raw2 = 0; m_db = 0; m_db_prev = 0;
        @(posedge clk); #1;

        // 1: reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            button = 1'($urandom); run_mode = 1'($urandom); bp_en = 1'($urandom);
            bp_addr = 8'($urandom); i_addr = 8'($urandom); halt_req = 1'($urandom);
            cycle();
        end
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        button = 0; run_mode = 0; bp_en = 0; halt_req = 0; i_addr = 0;
        cycle();
        reset = 0;

        // 2: glitch rejected, long press gives exactly one step
        cycles(3, 0);
        button = 1; cycles(2, 0);
        button = 0; cycles(10, 0);
        chk("glitch_count", 32'(step_count), 32'd0);
        button = 1; cycles(20, 0);
        button = 0; cycles(10, 0);
        chk("press1_count", 32'(step_count), 32'd1);
        chk("press1_idle", 32'(state), 32'(S_IDLE));
        button = 1; cycles(20, 0);
        button = 0; cycles(10, 0);
        chk("press2_count", 32'(step_count), 32'd2);

        // 3: free-run up to breakpoint at 0x05
        reset = 1; cycle(); reset = 0;
        m_pc = 0; i_addr = 0; bp_en = 1; bp_addr = 8'h05; run_mode = 1;
        cycles(7, 1);
        chk("bp_state", 32'(state), 32'(S_BREAK));
        chk("bp_at_break", 32'(at_break), 32'd1);
        chk("bp_count", 32'(step_count), 32'd5);
        chk("bp_pc", 32'(m_pc), 32'h05);

        // 4: step past breakpoint, then resume run
        button = 1; cycles(20, 1);
        chk("step_past_count", 32'(step_count), 32'd6);
        chk("step_past_state", 32'(state), 32'(S_WAIT));
        button = 0; cycles(10, 1);
        chk("resume_state", 32'(state), 32'(S_RUN));
        chk("resume_at_break", 32'(at_break), 32'd0);

        // 5: halt request stops immediately, run_mode low returns to idle
        halt_req = 1; cycles(1, 1);
        chk("halt_state", 32'(state), 32'(S_BREAK));
        halt_req = 0; run_mode = 0; cycles(1, 1);
        chk("halt_idle", 32'(state), 32'(S_IDLE));

        // Random phase
        bp_addr = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)  button   = ~button;
            if ($urandom_range(0, 29) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 39) == 0) bp_en    = ~bp_en;
            halt_req = ($urandom_range(0, 19) == 0);
            cycles(1, 1);
        end
        button = 0; run_mode = 0; halt_req = 0; bp_en = 0;
        cycles(10, 1);

        // 6: reset mid-run at 37, then counter wrap
        reset = 1; cycle(); reset = 0;
        run_mode = 1;
        cycles(38, 1);
        chk("run37_count", 32'(step_count), 32'd37);
        reset = 1; cycle(); reset = 0;
        chk("midrst_state", 32'(state), 32'(S_IDLE));
        chk("midrst_count", 32'(step_count), 32'd0);
        chk("midrst_ce", 32'(cpu_ce), 32'd0);
        cycles(1 + 65535, 1);
        chk("wrap_pre", 32'(step_count), 32'hFFFF);
        cycles(1, 1);
        chk("wrap_zero", 32'(step_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
